// File: rtl/argmax_classifier_if.sv
// ---------------------------------------------------------------------------
// argmax_classifier_if
//   Groups the logit input stream and the classification result handshake.
//
//   Input stream : in_valid, in_ready, in_logit[LOGIT_W], in_last
//   Result       : out_valid, out_ready, out_class[IDX_W], out_max[LOGIT_W],
//                  out_margin[LOGIT_W+1], out_err
//
//   slave  : the argmax block (consumes logits, produces the result)
//   master : the surrounding logic (produces logits, consumes the result)
// ---------------------------------------------------------------------------
interface argmax_classifier_if #(
    parameter int LOGIT_W = 8,
    parameter int IDX_W   = 1
);
    logic               in_valid;
    logic               in_ready;
    logic [LOGIT_W-1:0] in_logit;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_class;
    logic [LOGIT_W-1:0] out_max;
    logic [LOGIT_W:0]   out_margin;
    logic               out_err;

    modport slave (
        input  in_valid, in_logit, in_last, out_ready,
        output in_ready, out_valid, out_class, out_max, out_margin, out_err
    );

    modport master (
        output in_valid, in_logit, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_max, out_margin, out_err
    );
endinterface

// File: rtl/argmax_classifier.sv
// ---------------------------------------------------------------------------
// argmax_classifier
//   Streaming argmax over one vector of NUM_CLASSES logits (one per beat).
//   Tracks the best and runner-up logit while the vector streams in, then
//   presents the winning class, its logit, the margin to the runner-up and a
//   length-error flag through a valid/ready handshake.
//
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : argmax_classifier_if.slave
//              in_valid/in_ready/in_logit/in_last  logit stream
//              out_valid/out_ready                 result handshake
//              out_class  winning index (lowest index on ties)
//              out_max    winning logit
//              out_margin unsigned best - runner-up, LOGIT_W+1 bits
//              out_err    vector ended early (in_last) or ran long (no in_last)
// ---------------------------------------------------------------------------
module argmax_classifier #(
    parameter int NUM_CLASSES   = 2,
    parameter int LOGIT_W       = 8,
    parameter bit SIGNED_LOGITS = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    argmax_classifier_if.slave bus
);
    localparam int IDX_W = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    // Seed for the runner-up so that any real logit beats it.
    localparam logic [LOGIT_W-1:0] MIN_LOGIT =
        SIGNED_LOGITS ? {1'b1, {(LOGIT_W-1){1'b0}}} : {LOGIT_W{1'b0}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic logic f_gt(input logic [LOGIT_W-1:0] a,
                                  input logic [LOGIT_W-1:0] b);
        logic signed [LOGIT_W-1:0] sa;
        logic signed [LOGIT_W-1:0] sb;
        sa = a;
        sb = b;
        if (SIGNED_LOGITS) return sa > sb;
        return a > b;
    endfunction

    // One extra bit holds the full span (e.g. 127 - (-128) = 255 for 8 bits).
    function automatic logic [LOGIT_W:0] f_margin(input logic [LOGIT_W-1:0] hi,
                                                  input logic [LOGIT_W-1:0] lo);
        logic signed [LOGIT_W:0] ext_hi;
        logic signed [LOGIT_W:0] ext_lo;
        logic signed [LOGIT_W:0] diff;
        ext_hi = SIGNED_LOGITS ? {hi[LOGIT_W-1], hi} : {1'b0, hi};
        ext_lo = SIGNED_LOGITS ? {lo[LOGIT_W-1], lo} : {1'b0, lo};
        diff   = ext_hi - ext_lo;
        return diff;
    endfunction

    state_t             r_state;
    logic [IDX_W-1:0]   r_count;
    logic               r_in_ready;

    logic [LOGIT_W-1:0] r_best_p0;
    logic [LOGIT_W-1:0] r_second_p0;
    logic [IDX_W-1:0]   r_idx_p0;

    logic               r_vld_p1;
    logic [IDX_W-1:0]   r_class_p1;
    logic [LOGIT_W-1:0] r_max_p1;
    logic [LOGIT_W:0]   r_margin_p1;
    logic               r_err_p1;

    logic               w_accept;
    logic               w_first;
    logic               w_last_beat;
    logic               w_end;
    logic               w_len_err;
    logic [LOGIT_W-1:0] w_best_nxt;
    logic [LOGIT_W-1:0] w_second_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_first     = (r_count == '0);
    assign w_last_beat = (r_count == LAST_IDX);
    assign w_end       = w_last_beat || bus.in_last;
    // Error when in_last and the final slot disagree: early last or missing last.
    assign w_len_err   = bus.in_last ^ w_last_beat;

    // Stage p0: running best / runner-up including the current beat
    always_comb begin
        w_best_nxt   = r_best_p0;
        w_second_nxt = r_second_p0;
        w_idx_nxt    = r_idx_p0;
        if (w_first) begin
            w_best_nxt   = bus.in_logit;
            w_second_nxt = MIN_LOGIT;
            w_idx_nxt    = '0;
        end else if (f_gt(bus.in_logit, r_best_p0)) begin
            w_best_nxt   = bus.in_logit;
            w_second_nxt = r_best_p0;
            w_idx_nxt    = r_count;
        end else if (f_gt(bus.in_logit, r_second_p0)) begin
            w_second_nxt = bus.in_logit;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_best_p0   <= w_best_nxt;
            r_second_p0 <= w_second_nxt;
            r_idx_p0    <= w_idx_nxt;
        end
    end

    // Stage p1: control FSM and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_vld_p1    <= 1'b0;
            r_class_p1  <= '0;
            r_max_p1    <= '0;
            r_margin_p1 <= '0;
            r_err_p1    <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_end) begin
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_vld_p1    <= 1'b1;
                            r_class_p1  <= w_idx_nxt;
                            r_max_p1    <= w_best_nxt;
                            // A single-beat vector has no runner-up to compare.
                            r_margin_p1 <= w_first ? '0 : f_margin(w_best_nxt, w_second_nxt);
                            r_err_p1    <= w_len_err;
                        end else begin
                            r_count <= r_count + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // No bypass: the next vector starts the cycle after the handshake.
                    if (bus.out_ready) begin
                        r_state    <= ACCUM;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_vld_p1   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_vld_p1;
    assign bus.out_class  = r_class_p1;
    assign bus.out_max    = r_max_p1;
    assign bus.out_margin = r_margin_p1;
    assign bus.out_err    = r_err_p1;
endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Synthesizable argmax stage at the tail of top_cnn. Replaces the software class decision with hardware.
- Consumes the final dense layer's logits as a serial stream, one logit per beat.
- Emits the winning class index, the winning logit and the confidence margin (max minus runner-up) through a valid/ready handshake.
- Generalised over class count, logit width and signedness. Detects malformed (short/long) logit vectors.

Parameters:
- NUM_CLASSES, 2, number of logits per vector; legal range is 2 or more.
- LOGIT_W, 8, logit width in bits.
- SIGNED_LOGITS, 1, 1 = two's-complement compare, 0 = unsigned compare.
- IDX_W, $clog2(NUM_CLASSES), class index width (derived localparam, minimum 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  logit beat valid.
- in_ready  out  1  block can accept a beat.
- in_logit  in  LOGIT_W  logit value.
- in_last  in  1  final logit of the vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_class  out  IDX_W  argmax index.
- out_max  out  LOGIT_W  winning logit.
- out_margin  out  LOGIT_W+1  unsigned (max - second max).
- out_err  out  1  vector length mismatch flag.

Behaviour:
- States: ACCUM and HOLD.
- Reset (sync, rst=1 at a clk edge):
  - state=ACCUM, beat count=0, in_ready=1.
  - out_valid=0, out_class=0, out_max=0, out_margin=0, out_err=0.
  - Reset mid-vector discards the partial vector.
- in_ready=1 only in ACCUM. A beat is accepted when in_valid && in_ready. in_logit and in_last are ignored on non-accepted cycles.
- Beat k (k = count, 0-based):
  - k=0: best=logit, idx=0, second=minimum representable value (0x80.. when signed, 0 when unsigned).
  - k>0, logit > best (strict): second=best, best=logit, idx=k.
  - else if logit > second: second=logit.
  - Ties keep the lowest index.
  - Comparison is signed or unsigned per SIGNED_LOGITS.
- Vector end: the accepted beat with k==NUM_CLASSES-1 or in_last=1, whichever comes first.
- On vector end, in the next cycle:
  - out_valid=1 and state goes to HOLD.
  - out_class/out_max are registered from the final best/idx.
  - out_margin = best - second, computed sign-correctly in LOGIT_W+1 bits and always ≥0. It is forced to 0 if only one beat was received.
  - out_err=1 if in_last arrived with k<NUM_CLASSES-1, or if k==NUM_CLASSES-1 with in_last=0. Otherwise out_err=0.
  - On a short vector the result is computed over the beats received.
- Latency: out_valid rises 1 cycle after the final beat is accepted.
- HOLD:
  - All out_* are stable while out_valid && !out_ready.
  - On out_valid && out_ready, the next cycle has out_valid=0, state=ACCUM, count=0, in_ready=1.
  - Outputs keep their last values after out_valid drops.
- No bypass: a new vector cannot start in the handshake cycle. Throughput is NUM_CLASSES+1 cycles per vector with out_ready held at 1.
- in_valid asserted during HOLD has no effect.

Test Plan:
- Default params, signed: beats 0x05, 0x03(last) -> out_valid 1 cycle after beat 2; class=0, max=0x05, margin=2, err=0.
- Tie: 0x0A, 0x0A(last) -> class=0, margin=0. Extreme case: 0x80, 0x7F(last) -> class=1, max=0x7F, margin=255 (9-bit).
- NUM_CLASSES=10, signed, logits -3,-128,4,0,-1,20,19,127,126,-5(last) -> class=7, max=0x7F, margin=1, err=0. Throughput of 11 cycles/vector on back-to-back vectors.
- SIGNED_LOGITS=0: 0x80, 0x7F(last) -> class=0, max=0x80, margin=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid held high -> outputs constant and in_ready=0. Release -> out_valid=0 and in_ready=1 the next cycle, and the next vector is accepted correctly.
- NUM_CLASSES=10: in_last on beat 3 (logits 1,9,2(last)) -> class=1, margin=7, err=1. Then rst after 4 beats of a new vector, followed by a clean 10-beat vector -> correct result with err=0.
